memory_responder: RTL and testbench
===================================

# memory_responder

Bus-side responder for the CPU core's memory interface: a 16-bit address, 8-bit bidirectional data bus with `mem_read`/`mem_write` requests and a `mem_ready` completion. It holds a byte-wide internal RAM, inserts a programmable number of wait states, and enforces user/kernel protection on the upper half of the address space. It also has a side load port so benches and the boot loader can preload memory.

## Interface
- `RAM_AW`, default 12: RAM index width; depth is 2^RAM_AW bytes, indexed by `addr_bus[RAM_AW-1:0]`. Higher address bits alias.
- `WAIT_CYCLES`, default 1: wait states inserted between request accept and `mem_ready`; legal range 0..15.
- `clk` input 1: clock. All logic is on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `addr_bus` input 16: access address from the CPU.
- `data_bus` inout 8: driven by the block only for read responses, otherwise high-Z.
- `mem_read` input 1: read request, held by the CPU until it sees `mem_ready`.
- `mem_write` input 1: write request, held by the CPU until it sees `mem_ready`.
- `mem_ready` output 1: one-cycle completion pulse, registered.
- `user_mode` input 1: CPU privilege level; 1 means user.
- `fault` output 1: one-cycle pulse, coincident with the `mem_ready` of a faulting access.
- `fault_addr` output 16: address of the most recent faulting access; holds until the next fault.
- `load_en` input 1: side-port write strobe.
- `load_addr` input RAM_AW: side-port write index.
- `load_data` input 8: side-port write data.
- `load_ready` output 1: high when the FSM is in IDLE; `load_en` is ignored while this is low.

## Operation
- States are IDLE, WAIT and RESPOND.
- **IDLE**
  - If `mem_read | mem_write` is high, latch `addr_bus` into `acc_addr`, latch the access type, and evaluate the fault condition.
  - Next state is WAIT if `WAIT_CYCLES > 0`, otherwise RESPOND.
  - The wait counter loads `WAIT_CYCLES-1`.
- **WAIT**
  - The counter decrements each cycle; the FSM moves to RESPOND on the cycle the counter is 0.
  - If both requests drop (abort), return to IDLE: no `mem_ready`, no write, no fault.
- **RESPOND**
  - `mem_ready` = 1 for exactly this cycle; next state is IDLE unconditionally.
  - Read: drive `data_bus` with RAM[`acc_addr`] using an asynchronous read.
  - Write: capture `data_bus` into RAM[`acc_addr`] at the edge that ends RESPOND.
- **Fault conditions**, evaluated at accept:
  - `user_mode` = 1 and `addr_bus[15]` = 1, or
  - `mem_read` and `mem_write` both high (protocol error).
- **On a fault:**
  - A read returns `8'hFF`.
  - A write is suppressed.
  - A simultaneous read/write is treated as a suppressed write and the bus is not driven.
  - `fault` pulses with `mem_ready`, and `fault_addr` updates at the edge that ends RESPOND.
- **Load port**
  - When `load_en` is high in IDLE, RAM[`load_addr`] <= `load_data` at that edge.
  - A request accepted in the same cycle is legal; its CPU write lands later, so there is no collision.
- **Bus drive**: `data_bus` is driven only when state = RESPOND, the access is a read, and `mem_write` = 0. It is high-Z in every other cycle.

## Timing
- A request sampled high at edge N is accepted at N. `mem_ready` is high during cycle N+1+`WAIT_CYCLES`. Read data is valid in that same cycle; the CPU samples it at the following edge.
- Back-to-back accesses: IDLE is occupied for at least one cycle between accesses. A request still high in that IDLE cycle counts as a new access.
- Address and data are not re-sampled during WAIT; later changes to `addr_bus` are ignored.
- Reset values: state IDLE, `mem_ready` 0, `fault` 0, `fault_addr` 16'h0000, `data_bus` high-Z, `load_ready` 1, counter 0. RAM contents are not reset.
- Reset asserted mid-access: the access is aborted, no write occurs, and no `mem_ready` is issued after release.
- Address aliasing: with RAM_AW = 12, 0x8000 and 0x0000 map to the same byte (kernel protection is still applied by bit 15).

## Structure
- Shared package/include `mem_responder_defs`:
  - state encodings IDLE = 2'd0, WAIT = 2'd1, RESPOND = 2'd2;
  - `KERNEL_BIT` = 15;
  - `FAULT_DATA` = 8'hFF.
- Sub-module `byte_ram`:
  - parameterized on RAM_AW;
  - one asynchronous read port;
  - one synchronous write port;
  - the write port is muxed in the parent between the CPU write and the load port (both cannot occur in the same cycle by construction).
- The parent holds the FSM, the wait counter, the fault logic and the tri-state driver.

## Test plan
- Preload RAM[0x010] = 0xA5 via the load port; kernel read of 0x0010 with WAIT_CYCLES = 1 -> `mem_ready` two cycles after accept, `data_bus` = 0xA5, `fault` = 0.
- Kernel write of 0x3C to 0x8020, then read of 0x0020 (RAM_AW = 12) -> returns 0x3C, confirming aliasing.
- User-mode write of 0x55 to 0x9000, then kernel read of 0x9000 -> `fault` pulse on the write and `fault_addr` = 0x9000; RAM is unchanged and the read returns the prior value. A user-mode read of 0x9000 returns 0xFF with `fault`.
- `mem_read` dropped after 1 cycle with WAIT_CYCLES = 3 -> no `mem_ready`, `data_bus` stays high-Z, FSM back in IDLE; a subsequent read completes normally.
- `mem_read` and `mem_write` asserted together at 0x0040 -> `fault` = 1, RAM[0x040] unchanged, bus not driven. Separately, pulse `rst_n` low during WAIT of a write -> target byte unchanged, all outputs at reset values.
- Instantiate with WAIT_CYCLES = 0 and run back-to-back reads -> `mem_ready` every second cycle, with one IDLE cycle between pulses.

Source files
------------

// File: rtl/mem_responder_defs.sv
// rtl/mem_responder_defs.sv - shared encodings and constants for memory_responder
package mem_responder_defs;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } state_t;

  localparam int         KERNEL_BIT = 15;
  localparam logic [7:0] FAULT_DATA = 8'hFF;

  // Kernel half is off limits to user mode; asserting both strobes is a protocol error.
  function automatic logic access_faults(input logic        user_mode,
                                         input logic [15:0] addr,
                                         input logic        rd,
                                         input logic        wr);
    return (user_mode && addr[KERNEL_BIT]) || (rd && wr);
  endfunction

endpackage

// File: rtl/memory_responder_if.sv
// rtl/memory_responder_if.sv - CPU-side memory request/response signals
interface memory_responder_if;
  logic [15:0] addr_bus;
  logic        mem_read;
  logic        mem_write;
  logic        user_mode;
  logic        mem_ready;
  logic        fault;
  logic [15:0] fault_addr;

  modport master (
    output addr_bus, mem_read, mem_write, user_mode,
    input  mem_ready, fault, fault_addr
  );

  modport slave (
    input  addr_bus, mem_read, mem_write, user_mode,
    output mem_ready, fault, fault_addr
  );
endinterface

// File: rtl/byte_ram.sv
// rtl/byte_ram.sv - byte RAM with asynchronous read and synchronous write
module byte_ram #(
  parameter int RAM_AW = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [RAM_AW-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [RAM_AW-1:0] raddr,
  output logic [7:0]        rdata
);
  logic [7:0] mem [2**RAM_AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - wait-stated, protection-checking memory responder with a load port
module memory_responder
  import mem_responder_defs::*;
#(
  parameter int RAM_AW      = 12,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  memory_responder_if.slave bus,
  inout  wire  [7:0]        data_bus,
  input  logic              load_en,
  input  logic [RAM_AW-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              load_ready
);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [15:0] acc_addr;
  logic        acc_write;
  logic        acc_fault;
  logic        ready_q;
  logic        fault_q;
  logic [15:0] fault_addr_q;
  logic        load_ready_q;

  logic              req;
  logic              req_fault;
  logic              cpu_we;
  logic              ram_we;
  logic              drive;
  logic [RAM_AW-1:0] ram_waddr;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;

  assign req       = bus.mem_read | bus.mem_write;
  assign req_fault = access_faults(bus.user_mode, bus.addr_bus, bus.mem_read, bus.mem_write);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wait_cnt     <= 4'd0;
      acc_addr     <= 16'h0000;
      acc_write    <= 1'b0;
      acc_fault    <= 1'b0;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
      fault_addr_q <= 16'h0000;
      load_ready_q <= 1'b1;
    end else begin
      ready_q <= 1'b0;
      fault_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            acc_addr     <= bus.addr_bus;
            acc_write    <= bus.mem_write;
            acc_fault    <= req_fault;
            wait_cnt     <= WAIT_LOAD;
            load_ready_q <= 1'b0;
            if (WAIT_CYCLES > 0) begin
              state <= WAIT;
            end else begin
              state   <= RESPOND;
              ready_q <= 1'b1;
              fault_q <= req_fault;
            end
          end
        end
        WAIT: begin
          // Dropping both strobes abandons the access before anything is committed.
          if (!bus.mem_read && !bus.mem_write) begin
            state        <= IDLE;
            wait_cnt     <= 4'd0;
            load_ready_q <= 1'b1;
          end else if (wait_cnt == 4'd0) begin
            state   <= RESPOND;
            ready_q <= 1'b1;
            fault_q <= acc_fault;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESPOND: begin
          state        <= IDLE;
          load_ready_q <= 1'b1;
          if (acc_fault) begin
            fault_addr_q <= acc_addr;
          end
        end
        default: begin
          state        <= IDLE;
          load_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // CPU writes land only while in RESPOND and loads only in IDLE, so the port is never contended.
  assign cpu_we    = (state == RESPOND) && acc_write && !acc_fault;
  assign ram_we    = cpu_we || (load_en && (state == IDLE));
  assign ram_waddr = cpu_we ? acc_addr[RAM_AW-1:0] : load_addr;
  assign ram_wdata = cpu_we ? data_bus : load_data;

  byte_ram #(.RAM_AW(RAM_AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (acc_addr[RAM_AW-1:0]),
    .rdata (ram_rdata)
  );

  assign drive    = (state == RESPOND) && !acc_write && !bus.mem_write;
  assign data_bus = drive ? (acc_fault ? FAULT_DATA : ram_rdata) : 8'hzz;

  assign bus.mem_ready  = ready_q;
  assign bus.fault      = fault_q;
  assign bus.fault_addr = fault_addr_q;
  assign load_ready     = load_ready_q;
endmodule

// File: tb/tb_memory_responder.sv
// tb/tb_memory_responder.sv - self-checking bench for memory_responder (WAIT_CYCLES 1, 3 and 0)
module tb_memory_responder;
  localparam int N = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] t_addr  [N];
  logic        t_rd    [N];
  logic        t_wr    [N];
  logic        t_user  [N];
  logic [7:0]  t_wdata [N];
  logic        t_len   [N];
  logic [11:0] t_laddr [N];
  logic [7:0]  t_ldata [N];

  wire [N-1:0] o_ready;
  wire [N-1:0] o_fault;
  wire [N-1:0] o_lr;
  wire [15:0]  o_faddr [N];
  wire [7:0]   o_data  [N];

  for (genvar g = 0; g < N; g++) begin : gd
    memory_responder_if bif ();
    wire [7:0] dbus;

    assign bif.addr_bus  = t_addr[g];
    assign bif.mem_read  = t_rd[g];
    assign bif.mem_write = t_wr[g];
    assign bif.user_mode = t_user[g];
    assign dbus = t_wr[g] ? t_wdata[g] : 8'hzz;
    for (genvar b = 0; b < 8; b++) begin : pd
      pulldown (dbus[b]);
    end

    memory_responder #(
      .RAM_AW      (12),
      .WAIT_CYCLES ((g == 0) ? 1 : (g == 1) ? 3 : 0)
    ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bif),
      .data_bus   (dbus),
      .load_en    (t_len[g]),
      .load_addr  (t_laddr[g]),
      .load_data  (t_ldata[g]),
      .load_ready (o_lr[g])
    );

    assign o_ready[g] = bif.mem_ready;
    assign o_fault[g] = bif.fault;
    assign o_faddr[g] = bif.fault_addr;
    assign o_data[g]  = dbus;
  end

  function automatic int wait_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 3 : 0;
  endfunction

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: an accepted access completes at a known edge unless both strobes drop first.
  int          cyc = 0;
  bit          m_pend  [N];
  int          m_resp  [N];
  logic [15:0] m_addr  [N];
  bit          m_wr    [N];
  bit          m_flt   [N];
  logic [15:0] m_faddr [N] = '{default: 16'h0000};
  logic [7:0]  mm      [N][4096];
  bit          known   [N][4096];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0;
      for (int k = 0; k < N; k++) begin
        m_pend[k]  = 1'b0;
        m_faddr[k] = 16'h0000;
      end
    end else begin
      cyc++;
      for (int k = 0; k < N; k++) begin
        if (m_pend[k]) begin
          if (cyc == m_resp[k]) begin
            m_pend[k] = 1'b0;
            if (m_flt[k]) begin
              m_faddr[k] = m_addr[k];
            end else if (m_wr[k]) begin
              mm[k][m_addr[k][11:0]]    = t_wdata[k];
              known[k][m_addr[k][11:0]] = 1'b1;
            end
          end else if (!t_rd[k] && !t_wr[k]) begin
            m_pend[k] = 1'b0;
          end
        end else begin
          if (t_len[k]) begin
            mm[k][t_laddr[k]]    = t_ldata[k];
            known[k][t_laddr[k]] = 1'b1;
          end
          if (t_rd[k] || t_wr[k]) begin
            m_pend[k] = 1'b1;
            m_addr[k] = t_addr[k];
            m_wr[k]   = t_wr[k];
            m_flt[k]  = (t_user[k] && t_addr[k][15]) || (t_rd[k] && t_wr[k]);
            m_resp[k] = cyc + wait_of(k) + 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    logic       er;
    logic [7:0] ed;
    bit         dchk;
    for (int k = 0; k < N; k++) begin
      er   = m_pend[k] && (m_resp[k] == cyc + 1);
      dchk = 1'b1;
      ed   = 8'h00;
      if (er && !m_wr[k] && !t_wr[k]) begin
        if (m_flt[k])                       ed = 8'hFF;
        else if (known[k][m_addr[k][11:0]]) ed = mm[k][m_addr[k][11:0]];
        else                                dchk = 1'b0;
      end else if (t_wr[k]) begin
        ed = t_wdata[k];
      end
      check($sformatf("d%0d_mem_ready", k), 32'(o_ready[k]), 32'(er));
      check($sformatf("d%0d_fault", k), 32'(o_fault[k]), 32'(er && m_flt[k]));
      check($sformatf("d%0d_fault_addr", k), 32'(o_faddr[k]), 32'(m_faddr[k]));
      check($sformatf("d%0d_load_ready", k), 32'(o_lr[k]), 32'(!m_pend[k]));
      if (dchk) check($sformatf("d%0d_data_bus", k), 32'(o_data[k]), 32'(ed));
    end
  end

  // Called just after a rising edge; returns just after the edge that ends RESPOND.
  task automatic access(input int k, input logic rd, input logic wr, input logic usr,
                        input logic [15:0] a, input logic [7:0] wd,
                        output logic [7:0] rdat, output logic flt, output int lat);
    rdat = 8'h00;
    flt  = 1'b0;
    lat  = 0;
    t_rd[k]    = rd;
    t_wr[k]    = wr;
    t_user[k]  = usr;
    t_addr[k]  = a;
    t_wdata[k] = wd;
    @(posedge clk);
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      if (o_ready[k]) begin
        lat  = i;
        rdat = o_data[k];
        flt  = o_fault[k];
      end
      @(posedge clk);
    end
    #1;
    t_rd[k]   = 1'b0;
    t_wr[k]   = 1'b0;
    t_user[k] = 1'b0;
    if (lat == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL access_timeout dut%0d addr %04h: no mem_ready within 20 cycles", k, a);
    end
  endtask

  task automatic load(input int k, input logic [11:0] a, input logic [7:0] d);
    t_len[k]   = 1'b1;
    t_laddr[k] = a;
    t_ldata[k] = d;
    @(posedge clk);
    #1;
    t_len[k] = 1'b0;
  endtask

  initial begin
    logic [7:0] rd8;
    logic       f;
    int         lat;
    int         pulses;
    int         back2;
    logic       prev;

    for (int k = 0; k < N; k++) begin
      t_addr[k] = 16'h0; t_rd[k] = 1'b0; t_wr[k] = 1'b0; t_user[k] = 1'b0;
      t_wdata[k] = 8'h0; t_len[k] = 1'b0; t_laddr[k] = 12'h0; t_ldata[k] = 8'h0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_mem_ready", 32'(o_ready), 32'h0);
    check("reset_fault", 32'(o_fault), 32'h0);
    check("reset_load_ready", 32'(o_lr), 32'h7);
    check("reset_fault_addr", 32'(o_faddr[0]), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    load(0, 12'h010, 8'hA5);
    access(0, 1'b1, 1'b0, 1'b0, 16'h0010, 8'h00, rd8, f, lat);
    check("t1_read_data", 32'(rd8), 32'hA5);
    check("t1_latency", 32'(lat), 32'd2);
    check("t1_fault", 32'(f), 32'h0);

    access(0, 1'b0, 1'b1, 1'b0, 16'h8020, 8'h3C, rd8, f, lat);
    check("t2_write_fault", 32'(f), 32'h0);
    access(0, 1'b1, 1'b0, 1'b0, 16'h0020, 8'h00, rd8, f, lat);
    check("t2_alias_read", 32'(rd8), 32'h3C);

    load(0, 12'h000, 8'h11);
    access(0, 1'b0, 1'b1, 1'b1, 16'h9000, 8'h55, rd8, f, lat);
    check("t3_user_write_fault", 32'(f), 32'h1);
    check("t3_fault_addr", 32'(o_faddr[0]), 32'h9000);
    access(0, 1'b1, 1'b0, 1'b0, 16'h9000, 8'h00, rd8, f, lat);
    check("t3_kernel_read", 32'(rd8), 32'h11);
    check("t3_kernel_fault", 32'(f), 32'h0);
    access(0, 1'b1, 1'b0, 1'b1, 16'h9000, 8'h00, rd8, f, lat);
    check("t3_user_read", 32'(rd8), 32'hFF);
    check("t3_user_read_fault", 32'(f), 32'h1);

    load(1, 12'h050, 8'h77);
    t_rd[1]   = 1'b1;
    t_addr[1] = 16'h0050;
    @(posedge clk);
    @(posedge clk);
    #1 t_rd[1] = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_ready[1]) pulses++;
    end
    check("t4_abort_pulses", 32'(pulses), 32'd0);
    check("t4_abort_load_ready", 32'(o_lr[1]), 32'h1);
    @(posedge clk); #1;
    access(1, 1'b1, 1'b0, 1'b0, 16'h0050, 8'h00, rd8, f, lat);
    check("t4_read_after_abort", 32'(rd8), 32'h77);
    check("t4_latency", 32'(lat), 32'd4);

    load(0, 12'h040, 8'h99);
    access(0, 1'b1, 1'b1, 1'b0, 16'h0040, 8'h22, rd8, f, lat);
    check("t5_rdwr_fault", 32'(f), 32'h1);
    check("t5_rdwr_bus", 32'(rd8), 32'h22);
    check("t5_rdwr_fault_addr", 32'(o_faddr[0]), 32'h0040);
    access(0, 1'b1, 1'b0, 1'b0, 16'h0040, 8'h00, rd8, f, lat);
    check("t5_ram_unchanged", 32'(rd8), 32'h99);

    load(1, 12'h060, 8'h44);
    t_wr[1]    = 1'b1;
    t_addr[1]  = 16'h0060;
    t_wdata[1] = 8'h0F;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_mem_ready", 32'(o_ready), 32'h0);
    check("t5_rst_fault", 32'(o_fault), 32'h0);
    check("t5_rst_load_ready", 32'(o_lr), 32'h7);
    check("t5_rst_fault_addr", 32'(o_faddr[0]), 32'h0);
    t_wr[1] = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (o_ready[1]) pulses++;
    end
    check("t5_rst_no_ready", 32'(pulses), 32'd0);
    @(posedge clk); #1;
    access(1, 1'b1, 1'b0, 1'b0, 16'h0060, 8'h00, rd8, f, lat);
    check("t5_rst_byte_unchanged", 32'(rd8), 32'h44);

    load(2, 12'h001, 8'h5C);
    access(2, 1'b1, 1'b0, 1'b0, 16'h0001, 8'h00, rd8, f, lat);
    check("t6_latency", 32'(lat), 32'd1);
    check("t6_read_data", 32'(rd8), 32'h5C);
    t_rd[2]   = 1'b1;
    t_addr[2] = 16'h0001;
    pulses = 0;
    back2  = 0;
    prev   = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (o_ready[2]) begin
        pulses++;
        if (prev) back2++;
      end
      prev = o_ready[2];
    end
    t_rd[2] = 1'b0;
    check("t6_b2b_pulses", 32'(pulses), 32'd5);
    check("t6_b2b_adjacent", 32'(back2), 32'd0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
